decade_counter: RTL and testbench

DECADE_COUNTER -- requirements
Module: decade_counter

---
 rtl/decade_counter_pkg.sv | 23 ++
 rtl/decade_counter.sv | 54 +++++
 tb/tb_decade_counter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/decade_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decade_counter_pkg
//  Description : Shared defaults and helpers for cascadable decade counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package decade_counter_pkg;

    localparam int unsigned c_DEFAULT_MAX_COUNT = 9;
    localparam int unsigned c_DEFAULT_WIDTH     = 4;

    // Bits needed to hold a given terminal count; used to sanity-check WIDTH.
    function automatic int unsigned count_bits(input int unsigned max_count);
        int unsigned bits;
        bits = 1;
        while ((max_count >> bits) != 0) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage : decade_counter_pkg
`default_nettype wire

// File: rtl/decade_counter.sv
`default_nettype none
// ============================================================================
//  Module      : decade_counter
//  Description : Modulo-(MAX_COUNT+1) enable counter with terminal-count carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module decade_counter
    import decade_counter_pkg::*;
#(
    parameter int unsigned MAX_COUNT = c_DEFAULT_MAX_COUNT,
    parameter int unsigned WIDTH     = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    output logic [WIDTH-1:0] cnt,
    output logic             carry
);

    localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_next;
    logic             w_at_max;
    logic             w_illegal;

    assign w_at_max  = (r_cnt == c_MAX);
    assign w_illegal = (r_cnt > c_MAX);

    // Out-of-range values recover to zero on the next edge, independent of in.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_illegal) begin
            w_cnt_next = c_ZERO;
        end else if (in) begin
            w_cnt_next = w_at_max ? c_ZERO : (r_cnt + c_ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= c_ZERO;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign cnt   = r_cnt;
    assign carry = rst_n & in & w_at_max;

endmodule : decade_counter
`default_nettype wire

// File: tb/tb_decade_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decade_counter
//  Description : Scoreboard bench for decade_counter with a modulo-arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decade_counter;

    localparam int c_MAX   = 9;
    localparam int c_WIDTH = 4;

    typedef struct {
        logic [c_WIDTH-1:0] exp_cnt;
        logic               exp_carry;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               in;
    logic [c_WIDTH-1:0] cnt;
    logic               carry;

    exp_t q_exp[$];
    int   checks;
    int   errors;
    int   m_cnt;
    logic r_carry_smp;

    decade_counter #(
        .MAX_COUNT (c_MAX),
        .WIDTH     (c_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .cnt   (cnt),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counting is modulo (MAX+1); anything out of range, or reset, goes to 0.
    function automatic void model_push(input logic rst_v, input logic in_v);
        exp_t e;
        e.exp_carry = rst_v && in_v && (m_cnt == c_MAX);
        if (!rst_v || m_cnt > c_MAX) m_cnt = 0;
        else if (in_v)               m_cnt = (m_cnt + 1) % (c_MAX + 1);
        e.exp_cnt = c_WIDTH'(m_cnt);
        q_exp.push_back(e);
    endfunction

    task automatic step(input logic rst_v, input logic in_v);
        @(negedge clk);
        rst_n = rst_v;
        in    = in_v;
        model_push(rst_v, in_v);
    endtask

    task automatic step_illegal(input logic [c_WIDTH-1:0] val);
        @(negedge clk);
        force dut.r_cnt = val;
        rst_n = 1'b1;
        in    = 1'b0;
        m_cnt = int'(val);
        model_push(1'b1, 1'b0);
        #4;
        release dut.r_cnt;
    endtask

    // Monitor: carry sampled just before each edge, cnt just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            r_carry_smp = carry;
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                checks = checks + 2;
                if (r_carry_smp !== e.exp_carry) begin
                    errors = errors + 1;
                    $display("FAIL carry: got %b expected %b (t=%0t)", r_carry_smp, e.exp_carry, $time);
                end
                if (cnt !== e.exp_cnt) begin
                    errors = errors + 1;
                    $display("FAIL cnt: got %0d expected %0d (t=%0t)", cnt, e.exp_cnt, $time);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        m_cnt  = 0;
        rst_n  = 1'b0;
        in     = 1'b1;

        step(1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);

        step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);

        for (int i = 0; i < 9; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        step_illegal(4'd12);
        step_illegal(4'd15);
        step(1'b1, 1'b1);
        step_illegal(4'd10);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) != 0), $urandom_range(0, 1) != 0);
        end

        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (q_exp.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_decade_counter
`default_nettype wire
